// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux scan sequencer: widths, FSM state
// encoding and the select value each word starts from.
package mux_seq_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] start_sel(input bit msb_first);
    return msb_first ? SEL_W'(7) : SEL_W'(0);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Upstream valid/ready word channel feeding the mux scan sequencer.
interface mux_scan_sequencer_if;
  import mux_seq_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts CLK_DIV cycles while running and flags the last
// cycle of each bit period.
module bit_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign tick = run && (div_cnt == LAST);

  // NOTE: registers take <= so every flop samples pre-edge values; blocking
  // assignments here would make simulation order-dependent.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives an 8:1 mux as a parallel-to-serial path: latches a word, then walks
// the select through all eight positions with framing strobes.
module mux_scan_sequencer
  import mux_seq_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_scan_sequencer_if.slave   s,
  output logic [DATA_W-1:0]     mux_in,
  output logic [SEL_W-1:0]      mux_sel,
  output logic                  bit_valid,
  output logic                  bit_strobe,
  output logic                  first_bit,
  output logic                  last_bit,
  output logic                  frame_done
);

  state_t           state;
  logic [SEL_W-1:0] bit_idx;
  logic             tick;
  logic             terminal;
  logic             accept;

  bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state == SHIFT),
    .clear (accept),
    .tick  (tick)
  );

  // tick is only ever high in SHIFT, so terminal implies SHIFT.
  assign terminal = tick && (bit_idx == SEL_W'(7));

  // NOTE: s_ready is a plain continuous decode of registered state, so it
  // cannot form a latch or a combinational path from s_valid.
  assign s.s_ready = (state == IDLE) || terminal;
  assign accept    = s.s_valid && s.s_ready;

  // Reversing a 3-bit index is the same as XOR with 7, and bit_idx rests at
  // 0 in IDLE, so this also yields the start select while idle.
  assign mux_sel    = start_sel(MSB_FIRST) ^ bit_idx;
  assign bit_valid  = (state == SHIFT);
  assign bit_strobe = tick;
  assign first_bit  = (state == SHIFT) && (bit_idx == SEL_W'(0));
  assign last_bit   = (state == SHIFT) && (bit_idx == SEL_W'(7));
  assign frame_done = terminal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_idx <= '0;
      mux_in  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            bit_idx <= '0;
            mux_in  <= s.s_data;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bit_idx == SEL_W'(7)) begin
              bit_idx <= '0;
              if (accept) begin
                mux_in <= s.s_data;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + SEL_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: three sequencer configurations driven with directed and
// random traffic, compared cycle by cycle against a word/offset model.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tb_valid = 1'b0;
  logic [7:0] tb_data = 8'h00;

  always #5 clk = ~clk;

  mux_scan_sequencer_if bus0 ();
  mux_scan_sequencer_if bus1 ();
  mux_scan_sequencer_if bus2 ();

  assign bus0.s_valid = tb_valid;
  assign bus0.s_data  = tb_data;
  assign bus1.s_valid = tb_valid;
  assign bus1.s_data  = tb_data;
  assign bus2.s_valid = tb_valid;
  assign bus2.s_data  = tb_data;

  logic [7:0] mi [3];
  logic [2:0] ms [3];
  logic       bv [3];
  logic       bs [3];
  logic       fb [3];
  logic       lb [3];
  logic       fd [3];
  logic       rdy [3];

  assign rdy[0] = bus0.s_ready;
  assign rdy[1] = bus1.s_ready;
  assign rdy[2] = bus2.s_ready;

  mux_scan_sequencer #(.CLK_DIV(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s(bus0), .mux_in(mi[0]), .mux_sel(ms[0]),
    .bit_valid(bv[0]), .bit_strobe(bs[0]), .first_bit(fb[0]),
    .last_bit(lb[0]), .frame_done(fd[0]));

  mux_scan_sequencer #(.CLK_DIV(1), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(bus1), .mux_in(mi[1]), .mux_sel(ms[1]),
    .bit_valid(bv[1]), .bit_strobe(bs[1]), .first_bit(fb[1]),
    .last_bit(lb[1]), .frame_done(fd[1]));

  mux_scan_sequencer #(.CLK_DIV(256), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .s(bus2), .mux_in(mi[2]), .mux_sel(ms[2]),
    .bit_valid(bv[2]), .bit_strobe(bs[2]), .first_bit(fb[2]),
    .last_bit(lb[2]), .frame_done(fd[2]));

  // Observed outputs of the configuration currently under test.
  int         sel = 0;
  logic [7:0] obs_mux_in;
  logic [2:0] obs_sel;
  logic       obs_valid, obs_strobe, obs_first, obs_last, obs_done, obs_ready;
  logic [16:0] obs_vec;

  always_comb begin
    obs_mux_in = mi[sel];
    obs_sel    = ms[sel];
    obs_valid  = bv[sel];
    obs_strobe = bs[sel];
    obs_first  = fb[sel];
    obs_last   = lb[sel];
    obs_done   = fd[sel];
    obs_ready  = rdy[sel];
    obs_vec    = {obs_ready, obs_valid, obs_strobe, obs_first, obs_last,
                  obs_done, obs_sel, obs_mux_in};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a word is either absent or present at some cycle offset
  // since its handshake; every output follows from that offset arithmetically.
  int         md = 4;
  bit         mmsb = 1'b0;
  bit         m_busy = 1'b0;
  int         m_off = 0;
  logic [7:0] m_word = 8'h00;

  function automatic logic [16:0] model_out();
    int         k;
    logic [2:0] s3;
    logic       term;
    if (m_busy) begin
      k    = m_off / md;
      s3   = mmsb ? 3'(7 - k) : 3'(k);
      term = (m_off == 8 * md - 1);
      return {term, 1'b1, (m_off % md) == md - 1, k == 0, k == 7, term,
              s3, m_word};
    end
    return {1'b1, 5'b00000, (mmsb ? 3'd7 : 3'd0), m_word};
  endfunction

  function automatic logic model_bit();
    int k;
    k = m_off / md;
    return m_word[mmsb ? 7 - k : k];
  endfunction

  task automatic model_update(input logic v, input logic [7:0] d,
                              input logic r);
    logic ready_now;
    ready_now = !m_busy || (m_off == 8 * md - 1);
    if (!r) begin
      m_busy = 1'b0;
      m_off  = 0;
      m_word = 8'h00;
    end else if (v && ready_now) begin
      m_busy = 1'b1;
      m_off  = 0;
      m_word = d;
    end else if (m_busy) begin
      m_off++;
      if (m_off == 8 * md) begin
        m_busy = 1'b0;
        m_off  = 0;
      end
    end
  endtask

  int   cyc = 0;
  int   n_frames = 0;
  int   n_valid = 0;
  logic bits[$];
  int   strobe_at[$];

  // Drive inputs for one cycle, advance one edge, then check that cycle's
  // outputs half a period later.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    logic b;
    tb_valid = v;
    tb_data  = d;
    rst_n    = r;
    @(posedge clk);
    model_update(v, d, r);
    cyc++;
    @(negedge clk);
    check("outputs", 32'(obs_vec), 32'(model_out()));
    if (obs_strobe) begin
      b = obs_mux_in[obs_sel];
      bits.push_back(b);
      strobe_at.push_back(cyc);
      if (m_busy) check("mux_bit", 32'(b), 32'(model_bit()));
    end
    if (obs_done)  n_frames++;
    if (obs_valid) n_valid++;
  endtask

  task automatic start_phase(input int s, input int d, input bit msb,
                             input logic v, input logic [7:0] data);
    sel  = s;
    md   = d;
    mmsb = msb;
    repeat (3) cycle(v, data, 1'b0);
  endtask

  function automatic logic [7:0] pack_bits(input int first, input bit rev);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) w[rev ? 7 - i : i] = bits[first + i];
    return w;
  endfunction

  initial begin
    int         t_acc;
    int         frame_rel;
    logic       idle_33;
    logic [15:0] mask;
    logic       v;

    @(negedge clk);

    // ---- CLK_DIV=4, LSB first ----
    start_phase(0, 4, 1'b0, 1'b1, 8'hA5);
    bits.delete();
    n_frames = 0;
    cycle(1'b1, 8'hA5, 1'b1);
    t_acc = cyc;
    check("accept_on_release", 32'(obs_valid), 32'd1);
    check("first_word_in", 32'(obs_mux_in), 32'hA5);
    frame_rel = -1;
    idle_33   = 1'b1;
    repeat (33) begin
      cycle(1'b0, 8'($urandom), 1'b1);
      if (obs_done && frame_rel < 0) frame_rel = cyc + 1 - t_acc;
      if (cyc + 1 - t_acc == 33) idle_33 = obs_valid;
    end
    check("a5_bit_count", 32'(bits.size()), 32'd8);
    if (bits.size() >= 8) check("a5_serial", 32'(pack_bits(0, 1'b0)), 32'hA5);
    check("a5_frame_cycle", 32'(frame_rel), 32'd32);
    check("a5_idle_after", 32'(idle_33), 32'd0);
    check("a5_frame_count", 32'(n_frames), 32'd1);

    // Stall: upstream keeps offering changing words mid-frame.
    cycle(1'b1, 8'h96, 1'b1);
    for (int j = 1; j < 32; j++) cycle(1'b1, 8'($urandom), 1'b1);
    cycle(1'b1, 8'h4B, 1'b1);
    check("stall_pending_word", 32'(obs_mux_in), 32'h4B);
    check("stall_no_gap_first", 32'(obs_first), 32'd1);
    repeat (34) cycle(1'b0, 8'($urandom), 1'b1);

    // Reset during bit 3 aborts the word.
    cycle(1'b1, 8'h5A, 1'b1);
    repeat (13) cycle(1'b0, 8'h00, 1'b1);
    check("pre_reset_last_sel", 32'(obs_sel), 32'd3);
    n_frames = 0;
    cycle(1'b0, 8'h00, 1'b0);
    check("abort_valid", 32'(obs_valid), 32'd0);
    check("abort_sel", 32'(obs_sel), 32'd0);
    bits.delete();
    cycle(1'b1, 8'h01, 1'b1);
    repeat (34) cycle(1'b0, 8'h00, 1'b1);
    check("abort_frames", 32'(n_frames), 32'd1);
    if (bits.size() >= 8) check("after_abort_serial", 32'(pack_bits(0, 1'b0)), 32'h01);
    else check("after_abort_bits", 32'(bits.size()), 32'd8);

    repeat (400) cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 150) != 0);

    // ---- CLK_DIV=1, MSB first, back-to-back ----
    start_phase(1, 1, 1'b1, 1'b0, 8'h00);
    n_frames = 0;
    n_valid  = 0;
    bits.delete();
    strobe_at.delete();
    mask = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      v = (i <= 8);
      cycle(v, (i == 0) ? 8'h3C : 8'hC3, 1'b1);
      mask[i] = obs_ready;
    end
    check("b2b_valid_cycles", 32'(n_valid), 32'd16);
    check("b2b_frames", 32'(n_frames), 32'd2);
    check("b2b_ready_mask", 32'(mask), 32'h8080);
    check("b2b_strobes", 32'(strobe_at.size()), 32'd16);
    if (bits.size() >= 16) begin
      check("b2b_word0", 32'(pack_bits(0, 1'b1)), 32'h3C);
      check("b2b_word1", 32'(pack_bits(8, 1'b1)), 32'hC3);
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("b2b_idle", 32'(obs_valid), 32'd0);

    repeat (300) cycle(($urandom % 3) != 0, 8'($urandom), ($urandom % 100) != 0);

    // ---- CLK_DIV=256 boundary ----
    start_phase(2, 256, 1'b0, 1'b0, 8'h00);
    n_frames = 0;
    n_valid  = 0;
    bits.delete();
    strobe_at.delete();
    cycle(1'b1, 8'hE7, 1'b1);
    repeat (2060) cycle(1'b0, 8'($urandom), 1'b1);
    check("div256_valid_cycles", 32'(n_valid), 32'd2048);
    check("div256_strobes", 32'(strobe_at.size()), 32'd8);
    check("div256_frames", 32'(n_frames), 32'd1);
    for (int i = 1; i < strobe_at.size(); i++)
      check("div256_spacing", 32'(strobe_at[i] - strobe_at[i-1]), 32'd256);
    if (bits.size() >= 8) check("div256_serial", 32'(pack_bits(0, 1'b0)), 32'hE7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
